// File: rtl/imm_pkg.sv
// imm_pkg: immediate types, opcodes and funct3 shift codes (IMM_GEN_ZICSR_EN enables the CSR zimm type)
package imm_pkg;
  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_CSR, IMM_U, IMM_SHIFT
  } imm_src_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      imm_type;
  logic            illegal;
  modport master (output in_valid, instr, imm_src, out_ready,
                  input  in_ready, out_valid, imm, imm_type, illegal);
  modport slave  (input  in_valid, instr, imm_src, out_ready,
                  output in_ready, out_valid, imm, imm_type, illegal);
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational type select and XLEN extension (IMM_GEN_ZICSR_EN enables CSR zimm)
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 0
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_imm_src,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal
);
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic            w_sh;
  logic            w_w32;
  logic            w_dec_ill;
  logic            w_shamt_ill;
  logic [5:0]      w_shamt;
  imm_src_t        w_type;
  logic [XLEN-1:0] w_imm;
  assign w_op  = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_sh  = (w_f3 == F3_SLL) || (w_f3 == F3_SR);
  // pick the immediate type, either from the select input or from the opcode
  always_comb begin
    w_type    = IMM_NONE;
    w_w32     = 1'b0;
    w_dec_ill = 1'b0;
    if (!AUTO_DECODE)
      w_type = imm_src_t'(i_imm_src);
    else
      case (w_op)
        OP_LOAD, OP_JALR:  w_type = IMM_I;
        OP_IMM:            w_type = w_sh ? IMM_SHIFT : IMM_I;
        OP_STORE:          w_type = IMM_S;
        OP_BRANCH:         w_type = IMM_B;
        OP_JAL:            w_type = IMM_J;
        OP_LUI, OP_AUIPC:  w_type = IMM_U;
        OP_IMM32:
          if (XLEN == 64 && w_sh) begin
            w_type = IMM_SHIFT;
            w_w32  = 1'b1;
          end else
            w_dec_ill = 1'b1;
`ifdef IMM_GEN_ZICSR_EN
        OP_SYSTEM:         w_type = w_f3[2] ? IMM_CSR : IMM_NONE;
`endif
        default:           w_dec_ill = 1'b1;
      endcase
  end
  // word shifts and RV32 only have a 5-bit shamt; bit 25 set there is illegal
  assign w_shamt     = (XLEN == 64 && !w_w32) ? i_instr[25:20] : {1'b0, i_instr[24:20]};
  assign w_shamt_ill = (XLEN == 32 || w_w32) && i_instr[25];
  // extend the selected field to XLEN
  always_comb begin
    w_imm = '0;
    case (w_type)
      IMM_I:     w_imm = XLEN'($signed(i_instr[31:20]));
      IMM_S:     w_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      IMM_B:     w_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
      IMM_J:     w_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
      IMM_U:     w_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      IMM_SHIFT: w_imm = w_shamt_ill ? '0 : XLEN'(w_shamt);
`ifdef IMM_GEN_ZICSR_EN
      IMM_CSR:   w_imm = XLEN'(i_instr[19:15]);
`endif
      default:   w_imm = '0;
    endcase
  end
  assign o_imm      = w_imm;
  assign o_imm_type = w_type;
  assign o_illegal  = w_dec_ill || (w_type == IMM_SHIFT && w_shamt_ill);
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate decode behind a 2-entry registered skid buffer
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 0
) (
  input logic           clk,
  input logic           rst,
  imm_gen_pipe_if.slave bus
);
  localparam int W = XLEN + 4;
  logic [XLEN-1:0]     w_imm;
  logic [2:0]          w_type;
  logic                w_ill;
  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_cnt_nxt;
  logic [1:0][W-1:0]   r_mem;
  logic                r_wr;
  logic                r_rd;
  logic [1:0]          r_cnt;
  logic                r_in_ready;
  imm_decode #(.XLEN(XLEN), .AUTO_DECODE(AUTO_DECODE)) u_dec (
    .i_instr   (bus.instr),
    .i_imm_src (bus.imm_src),
    .o_imm     (w_imm),
    .o_imm_type(w_type),
    .o_illegal (w_ill)
  );
  assign w_push    = bus.in_valid && r_in_ready;
  assign w_pop     = (r_cnt != 2'd0) && bus.out_ready;
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);
  // the head slot is never the write slot while occupied, so stalled outputs hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem      <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_mem[r_wr] <= {w_imm, w_type, w_ill};
      if (w_push) r_wr <= ~r_wr;
      if (w_pop) r_rd <= ~r_rd;
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= w_cnt_nxt != 2'd2;
    end
  end
  assign bus.in_ready = r_in_ready;
  assign bus.out_valid = r_cnt != 2'd0;
  assign {bus.imm, bus.imm_type, bus.illegal} = r_mem[r_rd];
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the pipelined core's decode stage. It takes a 32-bit instruction word, either with an explicit immediate-type select or decoding the type from the opcode, and produces an XLEN-wide immediate. The result leaves through a 2-entry registered skid buffer with valid/ready handshakes on both sides. It replaces the single-cycle combinational extender and adds RV64 support, opcode auto-decode, illegal-shift detection and back-pressure.

## Interface
- XLEN, 32: datapath width; 32 or 64 only.
- AUTO_DECODE, 0: 1 = derive type from instr[6:0]/funct3 and ignore imm_src; 0 = use imm_src.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  instr/imm_src valid.
- in_ready  out  1  skid buffer can accept.
- instr  in  32  instruction word.
- imm_src  in  3  immediate type; encoding in Operation.
- out_valid  out  1  imm/imm_type/illegal valid.
- out_ready  in  1  consumer accepts.
- imm  out  XLEN  extended immediate.
- imm_type  out  3  type actually applied.
- illegal  out  1  immediate field illegal for this XLEN or opcode.

## Operation
- Type encoding: 000 none, 001 I, 010 S, 011 B, 100 J, 101 CSR zimm (macro-gated), 110 U, 111 shift-immediate.
- Immediate forms:
  - I, S, B and J are sign-extended from instr[31] to XLEN.
  - U is {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - Shift is zero-extended: shamt = instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
- Illegal shift: if XLEN=32 and instr[25]=1, set illegal=1 and imm=0.
- None, or unsupported type: imm=0, illegal=0.
- Auto-decode map:
  - 0000011 and 1100111 → I.
  - 0010011 → I, or shift when funct3 is 001/101.
  - 0100011 → S; 1100011 → B; 1101111 → J; 0110111/0010111 → U.
  - 0011011 with funct3 001/101 (XLEN=64 only) → shift, using a 5-bit shamt; instr[25]=1 → illegal.
  - Any other opcode → none with illegal=1.
- Handshake: transfer when valid && ready on the same cycle. Accepted words leave in order.
- Buffer:
  - 2 entries plus an occupancy count of 0–2.
  - in_ready = (count != 2) and is driven from a register, so there is no combinational path from out_ready.
  - Simultaneous push and pop leaves count unchanged.
- Stability: while out_valid && !out_ready, imm, imm_type and illegal hold stable.

## Timing
- Latency: 1 cycle. A word accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: 1 word per cycle while out_ready=1.
- Reset values: count=0, in_ready=1 from the first edge after rst falls, out_valid=0, imm=0, imm_type=000, illegal=0.
- Reset mid-operation: buffered entries are discarded immediately and asynchronously.
- Buffer full (count=2): in_ready=0, and in_valid is ignored.
- Buffer empty: out_valid=0, and out_ready is ignored.

## Configuration
- IMM_GEN_ZICSR_EN defined:
  - Type 101 gives zimm = instr[19:15] zero-extended.
  - Auto-decode maps opcode 1110011 with funct3[2]=1 to 101, and with funct3[2]=0 to none with illegal=0.
- IMM_GEN_ZICSR_EN undefined:
  - Type 101 gives imm=0.
  - Opcode 1110011 gives none with illegal=1.

## Structure
- Package imm_pkg:
  - imm_src enum constants (IMM_NONE … IMM_SHIFT).
  - Opcode localparams.
  - The funct3 shift codes.
- Sub-module imm_decode: purely combinational. It covers type selection and XLEN-parametrised extension, and produces {imm, imm_type, illegal}.
- imm_gen_pipe: instantiates imm_decode and contains only the skid buffer and handshake logic.

## Test plan
- I-type: XLEN=32, imm_src=001, instr=0xFFF00093 → imm=0xFFFFFFFF. With XLEN=64 → imm=0xFFFFFFFFFFFFFFFF.
- S and J, AUTO_DECODE=1:
  - 0xFE20AE23 → imm_type=010, imm=0xFFFFFFFC.
  - 0xFF9FF06F → imm_type=100, imm=0xFFFFFFF8.
- U-type, XLEN=64:
  - 0x123450B7 → imm=0x0000000012345000.
  - 0x80000037 → imm=0xFFFFFFFF80000000.
- Shift, instr=0x03F09093:
  - XLEN=64 → imm=63, illegal=0.
  - XLEN=32 → imm=0, illegal=1.
- Back-pressure: hold out_ready=0 and push 3 words → in_ready=0 after the 2nd is accepted, and the 3rd is held. Then raise out_ready → outputs appear in order, one per cycle, with stable data while stalled.
- Reset with 2 entries buffered → out_valid=0 immediately; in_ready=1 after rst falls; no stale word appears afterwards.
